// File: rtl/seq_mult_feeder.sv
// Operand FIFO and start/done sequencer feeding a multi-cycle signed multiplier.
// Define SEQ_FEED_TIMEOUT_EN to add the WAIT watchdog and the sticky timeout_err output.
module seq_mult_feeder #(
    parameter int WIDTH       = 32,
    parameter int DEPTH       = 4,
    parameter int MULT_CYCLES = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WIDTH-1:0]         in_a,
    input  logic [WIDTH-1:0]         in_b,
    output logic                     mult_start,
    output logic [WIDTH-1:0]         mult_a,
    output logic [WIDTH-1:0]         mult_b,
    input  logic                     mult_done,
    input  logic [2*WIDTH-1:0]       mult_p,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [2*WIDTH-1:0]       out_p,
`ifdef SEQ_FEED_TIMEOUT_EN
    output logic                     timeout_err,
`endif
    output logic [$clog2(DEPTH):0]   fifo_count
);

    // state | meaning
    // IDLE  | nothing in flight; pops the FIFO head when one is available
    // ISSUE | mult_start high for this single cycle
    // WAIT  | multiplier iterating; operands held, waiting for mult_done
    // HOLD  | product presented on out_p until out_ready

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_HOLD
    } state_t;

    state_t state;

    logic [WIDTH-1:0] mem_a [DEPTH];
    logic [WIDTH-1:0] mem_b [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic             fifo_empty;
    logic             push;
    logic             pop;

    assign fifo_empty = (count == '0);
    // in_ready ignores a same-cycle pop so a full FIFO never sees write+read together
    assign in_ready   = (count != CW'(DEPTH));
    assign fifo_count = count;
    assign push       = in_valid && in_ready;
    assign pop        = !fifo_empty &&
                        ((state == ST_IDLE) || ((state == ST_HOLD) && out_ready));

    always_ff @(posedge clk) begin
        if (push) begin
            mem_a[wr_ptr] <= in_a;
            mem_b[wr_ptr] <= in_b;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            if (push && !pop)      count <= count + CW'(1);
            else if (pop && !push) count <= count - CW'(1);
        end
    end

`ifdef SEQ_FEED_TIMEOUT_EN
    localparam int TW = $clog2(MULT_CYCLES + 3) + 1;
    // Loaded on the ISSUE cycle so terminal count lands MULT_CYCLES+3 cycles after mult_start
    localparam logic [TW-1:0] TMR_LOAD = TW'(MULT_CYCLES + 2);
    logic [TW-1:0] timer;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= ST_IDLE;
            mult_start <= 1'b0;
            mult_a     <= '0;
            mult_b     <= '0;
            out_valid  <= 1'b0;
            out_p      <= '0;
`ifdef SEQ_FEED_TIMEOUT_EN
            timer       <= '0;
            timeout_err <= 1'b0;
`endif
        end else begin
            mult_start <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (pop) begin
                        mult_a     <= mem_a[rd_ptr];
                        mult_b     <= mem_b[rd_ptr];
                        mult_start <= 1'b1;
                        state      <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
`ifdef SEQ_FEED_TIMEOUT_EN
                    timer <= TMR_LOAD;
`endif
                    state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (mult_done) begin
                        out_p     <= mult_p;
                        out_valid <= 1'b1;
                        state     <= ST_HOLD;
                    end
`ifdef SEQ_FEED_TIMEOUT_EN
                    else if (timer == '0) begin
                        out_p       <= '0;
                        out_valid   <= 1'b1;
                        timeout_err <= 1'b1;
                        state       <= ST_HOLD;
                    end else begin
                        timer <= timer - TW'(1);
                    end
`endif
                end
                ST_HOLD: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        if (pop) begin
                            mult_a     <= mem_a[rd_ptr];
                            mult_b     <= mem_b[rd_ptr];
                            mult_start <= 1'b1;
                            state      <= ST_ISSUE;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_mult_feeder.sv
// Directed scoreboard bench for seq_mult_feeder with a behavioural multiplier model.
// Build with SEQ_FEED_TIMEOUT_EN defined to cover the watchdog path.
module tb_seq_mult_feeder;

    localparam int W  = 32;
    localparam int D  = 4;
    localparam int MC = 32;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [W-1:0]    in_a = '0;
    logic [W-1:0]    in_b = '0;
    logic            mult_start;
    logic [W-1:0]    mult_a;
    logic [W-1:0]    mult_b;
    logic            mult_done;
    logic [2*W-1:0]  mult_p;
    logic            out_valid;
    logic            out_ready = 1'b0;
    logic [2*W-1:0]  out_p;
    logic [$clog2(D):0] fifo_count;
`ifdef SEQ_FEED_TIMEOUT_EN
    logic            timeout_err;
`endif

    seq_mult_feeder #(.WIDTH(W), .DEPTH(D), .MULT_CYCLES(MC)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_a       (in_a),
        .in_b       (in_b),
        .mult_start (mult_start),
        .mult_a     (mult_a),
        .mult_b     (mult_b),
        .mult_done  (mult_done),
        .mult_p     (mult_p),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_p      (out_p),
`ifdef SEQ_FEED_TIMEOUT_EN
        .timeout_err(timeout_err),
`endif
        .fifo_count (fifo_count)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    logic [63:0] sb[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Multiplier model: responds MC cycles after mult_start, or on manual request
    logic        model_auto = 1'b1;
    int          manual_req = 0;
    int          manual_seen = 0;
    int          start_cnt = 0;
    logic        stable_ok = 1'b1;
    logic        busy = 1'b0;
    int          cnt = 0;
    logic [W-1:0] cap_a, cap_b;
    logic signed [63:0] pa, pb;

    initial begin
        mult_done = 1'b0;
        mult_p    = '0;
        forever begin
            @(negedge clk);
            mult_done = 1'b0;
            if (!rst) begin
                busy = 1'b0;
            end else begin
                if (busy) begin
                    if (mult_a !== cap_a || mult_b !== cap_b) stable_ok = 1'b0;
                    cnt--;
                    if (cnt == 0) begin
                        pa = $signed(cap_a);
                        pb = $signed(cap_b);
                        mult_p    = pa * pb;
                        mult_done = 1'b1;
                        busy      = 1'b0;
                    end
                end
                if (mult_start) begin
                    start_cnt++;
                    if (model_auto) begin
                        cap_a = mult_a;
                        cap_b = mult_b;
                        cnt   = MC;
                        busy  = 1'b1;
                    end
                end
            end
            if (manual_req != manual_seen) begin
                manual_seen = manual_req;
                mult_done   = 1'b1;
                mult_p      = 64'd121;
            end
        end
    end

    // Monitor: every accepted product is checked against the scoreboard head
    initial begin
        logic [63:0] e;
        forever begin
            @(negedge clk);
            if (rst && out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL out_p_unexpected: got %0h expected no product", out_p);
                end else begin
                    e = sb.pop_front();
                    chk("out_p", out_p, e);
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [W-1:0] a, input logic [W-1:0] b);
        int k;
        in_valid = 1'b1;
        in_a = a;
        in_b = b;
        k = 0;
        while (!in_ready && k < 200) begin
            tick(1);
            k++;
        end
        if (!in_ready) begin
            n_checks++;
            n_fail++;
            $display("FAIL push_timeout: got in_ready=0 expected 1 within 200 cycles");
        end
        tick(1);
        in_valid = 1'b0;
    endtask

    task automatic wait_start(output int cyc);
        cyc = 0;
        while (!mult_start && cyc < 60) begin
            tick(1);
            cyc++;
        end
        if (!mult_start) begin
            n_checks++;
            n_fail++;
            $display("FAIL wait_start: got no mult_start expected one within 60 cycles");
        end
    endtask

    task automatic wait_valid(output int cyc);
        cyc = 0;
        while (!out_valid && cyc < 200) begin
            tick(1);
            cyc++;
        end
        if (!out_valid) begin
            n_checks++;
            n_fail++;
            $display("FAIL wait_valid: got out_valid=0 expected 1 within 200 cycles");
        end
    endtask

    task automatic drain();
        int k;
        k = 0;
        while ((sb.size() != 0 || out_valid) && k < 1000) begin
            tick(1);
            k++;
        end
        if (sb.size() != 0 || out_valid) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain: got %0d pending products expected 0", sb.size());
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got simulation still running expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int c;
        int sc0;

        // 1: reset holds the block empty even with in_valid asserted
        in_valid = 1'b1;
        in_a = 32'd1;
        in_b = 32'd2;
        tick(3);
        chk("rst_in_ready",   in_ready,   1);
        chk("rst_fifo_count", fifo_count, 0);
        chk("rst_mult_start", mult_start, 0);
        chk("rst_out_valid",  out_valid,  0);
        chk("rst_out_p",      out_p,      0);
        chk("rst_mult_a",     mult_a,     0);
`ifdef SEQ_FEED_TIMEOUT_EN
        chk("rst_timeout_err", timeout_err, 0);
`endif
        in_valid = 1'b0;
        rst = 1'b1;
        tick(2);
        chk("post_rst_count", fifo_count, 0);

        // 2: single op -7 * 6
        out_ready = 1'b0;
        sc0 = start_cnt;
        sb.push_back(-64'sd42);
        push(32'hFFFF_FFF9, 32'd6);
        chk("single_count", fifo_count, 1);
        wait_start(c);
        chk("single_start_lat", c, 1);
        chk("single_mult_a", mult_a, 32'hFFFF_FFF9);
        chk("single_mult_b", mult_b, 32'd6);
        tick(1);
        chk("single_start_pulse", mult_start, 0);
        wait_valid(c);
        chk("single_valid_lat", c, MC);
        tick(5);
        chk("single_hold_valid", out_valid, 1);
        chk("single_hold_p", out_p, -64'sd42);
        chk("single_starts", start_cnt - sc0, 1);
        chk("single_stable", stable_ok, 1);
        out_ready = 1'b1;
        tick(1);
        chk("single_released", out_valid, 0);

        // 3: fill the FIFO behind one in-flight op, then drain in order
        out_ready = 1'b0;
        sc0 = start_cnt;
        sb.push_back(64'd12);
        push(32'd3, 32'd4);
        sb.push_back(-64'sd25);
        push(32'hFFFF_FFFB, 32'd5);
        sb.push_back(-64'sd10000);
        push(32'd100, 32'hFFFF_FF9C);
        sb.push_back(64'd1);
        push(32'hFFFF_FFFF, 32'hFFFF_FFFF);
        sb.push_back(64'd2147483648);
        push(32'h8000_0000, 32'hFFFF_FFFF);
        chk("full_count", fifo_count, 4);
        chk("full_in_ready", in_ready, 0);
        in_valid = 1'b1;
        in_a = 32'd77;
        in_b = 32'd77;
        tick(3);
        chk("full_refused_ready", in_ready, 0);
        chk("full_refused_count", fifo_count, 4);
        in_valid = 1'b0;
        out_ready = 1'b1;
        drain();
        tick(40);
        chk("full_starts", start_cnt - sc0, 5);
        chk("full_empty", fifo_count, 0);
        chk("full_stable", stable_ok, 1);

        // 4: long backpressure in HOLD, then immediate back-to-back issue
        out_ready = 1'b0;
        sb.push_back(-64'sd81);
        push(32'd9, 32'hFFFF_FFF7);
        sb.push_back(64'd6);
        push(32'd2, 32'd3);
        wait_valid(c);
        sc0 = start_cnt;
        tick(100);
        chk("bp_valid", out_valid, 1);
        chk("bp_p", out_p, -64'sd81);
        chk("bp_no_start", start_cnt - sc0, 0);
        chk("bp_count", fifo_count, 1);
        out_ready = 1'b1;
        tick(1);
        chk("bp_next_start", mult_start, 1);
        chk("bp_next_a", mult_a, 32'd2);
        drain();

        // 5: reset in the middle of WAIT discards the op; stray done ignored
        model_auto = 1'b0;
        push(32'd11, 32'd11);
        wait_start(c);
        tick(10);
        rst = 1'b0;
        tick(2);
        chk("midrst_valid", out_valid, 0);
        chk("midrst_count", fifo_count, 0);
        chk("midrst_mult_a", mult_a, 0);
        rst = 1'b1;
        tick(1);
        manual_req++;
        tick(3);
        chk("stray_valid", out_valid, 0);
        chk("stray_p", out_p, 0);
        chk("stray_count", fifo_count, 0);
        chk("stray_start", mult_start, 0);
        model_auto = 1'b1;

`ifdef SEQ_FEED_TIMEOUT_EN
        // 6: multiplier never answers; watchdog fires at start+MC+4
        model_auto = 1'b0;
        out_ready = 1'b0;
        sb.push_back(64'd0);
        push(32'd5, 32'd5);
        wait_start(c);
        tick(MC + 3);
        chk("to_not_yet", out_valid, 0);
        tick(1);
        chk("to_valid", out_valid, 1);
        chk("to_p", out_p, 0);
        chk("to_err", timeout_err, 1);
        model_auto = 1'b1;
        out_ready = 1'b1;
        drain();
        sb.push_back(64'd4);
        push(32'd2, 32'd2);
        drain();
        chk("to_err_sticky", timeout_err, 1);
`endif

        tick(5);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
